// File: rtl/taxi_eth_mld_pkg.sv
// Shared constants for the MLD transmit path: sync headers, the
// per-lane alignment marker table and the BIP-8 helpers.
package taxi_eth_mld_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef enum logic {
    PH_DATA = 1'b0,
    PH_AM   = 1'b1
  } mld_phase_t;

  // {M2, M1, M0} per lane, lane 0 in the low bits
  localparam logic [3:0][23:0] AM_TBL = {
    24'h3D79A2,
    24'h9B65C5,
    24'hE6C4F0,
    24'h477690
  };

  function automatic logic [7:0] bip8_calc(
    input logic [63:0] data,
    input logic [1:0]  hdr
  );
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r ^= data[i*8 +: 8];
    r[3] ^= hdr[0];
    r[4] ^= hdr[1];
    return r;
  endfunction

  // bytes 0..7: M0 M1 M2 BIP3 ~M0 ~M1 ~M2 ~BIP3
  function automatic logic [63:0] am_word(
    input logic [1:0] lane,
    input logic [7:0] bip
  );
    logic [23:0] m;
    m = AM_TBL[lane];
    return {~bip, ~m, bip, m};
  endfunction

endpackage

// File: rtl/taxi_eth_mld_bip.sv
// Per-lane BIP-8 accumulator. Ports: i_load/i_load_val overwrite the
// parity, i_acc folds in i_data/i_hdr, o_value is the running parity.
module taxi_eth_mld_bip
  import taxi_eth_mld_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_load_val,
  input  logic        i_acc,
  input  logic [63:0] i_data,
  input  logic [1:0]  i_hdr,
  output logic [7:0]  o_value
);

  logic [7:0] r_bip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bip <= '0;
    else if (i_load)
      r_bip <= i_load_val;
    else if (i_acc)
      r_bip <= r_bip ^ bip8_calc(i_data, i_hdr);
  end

  assign o_value = r_bip;

endmodule

// File: rtl/taxi_eth_phy_mld_tx.sv
// MLD transmit: round-robins 66-bit blocks over LANES lanes and inserts
// per-lane alignment markers with BIP-8 every AM_PERIOD data words.
// Ports: encoded_tx_* block input (valid/ready), serdes_tx_* lane words,
// cfg_am_enable gates AM insertion, stat_am_inserted marks AM words.
module taxi_eth_phy_mld_tx
  import taxi_eth_mld_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int HDR_W     = 2,
  parameter int LANES     = 4,
  parameter int AM_PERIOD = 16383
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       encoded_tx_data,
  input  logic [HDR_W-1:0]        encoded_tx_hdr,
  input  logic                    encoded_tx_valid,
  output logic                    encoded_tx_ready,
  output logic [LANES*DATA_W-1:0] serdes_tx_data,
  output logic [LANES*HDR_W-1:0]  serdes_tx_hdr,
  output logic                    serdes_tx_valid,
  input  logic                    cfg_am_enable,
  output logic                    stat_am_inserted
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam logic [IW-1:0] LAST    = IW'(LANES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(AM_PERIOD - 1);

  mld_phase_t      r_phase, w_phase_n;
  logic [IW-1:0]   r_lane, w_lane_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_en, w_en_n;
  logic            w_last, w_acc, w_bound;
  logic            w_emit_data, w_emit_am, w_bip_load;

  logic [DATA_W-1:0] r_buf_d [LANES];
  logic [HDR_W-1:0]  r_buf_h [LANES];

  logic [LANES*DATA_W-1:0] w_blk_d, w_am_d, r_data;
  logic [LANES*HDR_W-1:0]  w_blk_h, r_hdr;
  logic                    r_valid, r_stat;

  assign w_last = (r_lane == LAST);
  assign w_acc  = (r_phase == PH_DATA) && encoded_tx_valid;

  always_comb begin
    w_phase_n   = r_phase;
    w_lane_n    = r_lane;
    w_cnt_n     = r_cnt;
    w_en_n      = r_en;
    w_emit_data = 1'b0;
    w_emit_am   = 1'b0;
    w_bound     = 1'b0;
    unique case (r_phase)
      PH_AM: begin
        w_lane_n = w_last ? '0 : r_lane + 1'b1;
        if (w_last) begin
          w_bound   = 1'b1;
          w_en_n    = cfg_am_enable;
          w_emit_am = cfg_am_enable;
          w_phase_n = PH_DATA;
          w_cnt_n   = '0;
        end
      end
      PH_DATA: begin
        if (w_acc) begin
          w_lane_n = w_last ? '0 : r_lane + 1'b1;
          if (w_last) begin
            w_bound     = 1'b1;
            w_emit_data = 1'b1;
            w_en_n      = cfg_am_enable;
            if (!cfg_am_enable) begin
              w_cnt_n = '0;
            end else if (!r_en || r_cnt == CNT_MAX) begin
              // enable just rose, or the period expired
              w_cnt_n   = '0;
              w_phase_n = PH_AM;
            end else begin
              w_cnt_n = r_cnt + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_AM;
      r_lane  <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_phase <= w_phase_n;
      r_lane  <= w_lane_n;
      r_cnt   <= w_cnt_n;
      r_en    <= w_en_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_buf_d[i] <= '0;
        r_buf_h[i] <= '0;
      end
    end else if (w_acc) begin
      r_buf_d[r_lane] <= encoded_tx_data;
      r_buf_h[r_lane] <= encoded_tx_hdr;
    end
  end

  // disabled AM insertion keeps every parity cleared
  assign w_bip_load = w_emit_am | (w_bound & ~cfg_am_enable);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic              w_cur;
    logic [7:0]        w_bip;
    logic [DATA_W-1:0] w_am;

    // the final block of a word bypasses the buffer
    assign w_cur = (r_lane == IW'(l));
    assign w_blk_d[l*DATA_W +: DATA_W] =
      w_cur ? encoded_tx_data : r_buf_d[l];
    assign w_blk_h[l*HDR_W +: HDR_W] =
      w_cur ? encoded_tx_hdr : r_buf_h[l];
    assign w_am = am_word(2'(l), w_bip);
    assign w_am_d[l*DATA_W +: DATA_W] = w_am;

    taxi_eth_mld_bip u_bip (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_bip_load),
      .i_load_val (w_emit_am ? bip8_calc(w_am, SYNC_CTRL) : 8'h00),
      .i_acc      (w_emit_data & cfg_am_enable),
      .i_data     (w_blk_d[l*DATA_W +: DATA_W]),
      .i_hdr      (w_blk_h[l*HDR_W +: HDR_W]),
      .o_value    (w_bip)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_hdr   <= '0;
      r_valid <= 1'b0;
      r_stat  <= 1'b0;
    end else begin
      r_valid <= w_emit_data | w_emit_am;
      r_stat  <= w_emit_am;
      if (w_emit_am) begin
        r_data <= w_am_d;
        r_hdr  <= {LANES{SYNC_CTRL}};
      end else if (w_emit_data) begin
        r_data <= w_blk_d;
        r_hdr  <= w_blk_h;
      end
    end
  end

  assign encoded_tx_ready = (r_phase == PH_DATA);
  assign serdes_tx_data   = r_data;
  assign serdes_tx_hdr    = r_hdr;
  assign serdes_tx_valid  = r_valid;
  assign stat_am_inserted = r_stat;

endmodule

// File: tb/tb_taxi_eth_phy_mld_tx.sv
// Scoreboard bench for taxi_eth_phy_mld_tx: a 4-lane instance with a
// short AM period and a 1-lane instance, driven with directed blocks.
module tb_taxi_eth_phy_mld_tx;

  typedef struct packed {
    logic [255:0] d;
    logic [7:0]   h;
    logic         s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rst_nb;
  logic [63:0]  da, db;
  logic [1:0]   ha, hb;
  logic         va, vb, rdya, rdyb, en_a, en_b;
  logic [255:0] sda;
  logic [63:0]  sdb;
  logic [7:0]   sha;
  logic [1:0]   shb;
  logic         sva, svb, sta, stb;

  taxi_eth_phy_mld_tx #(.LANES(4), .AM_PERIOD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .encoded_tx_data(da), .encoded_tx_hdr(ha),
    .encoded_tx_valid(va), .encoded_tx_ready(rdya),
    .serdes_tx_data(sda), .serdes_tx_hdr(sha),
    .serdes_tx_valid(sva), .cfg_am_enable(en_a),
    .stat_am_inserted(sta)
  );

  taxi_eth_phy_mld_tx #(.LANES(1), .AM_PERIOD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_nb),
    .encoded_tx_data(db), .encoded_tx_hdr(hb),
    .encoded_tx_valid(vb), .encoded_tx_ready(rdyb),
    .serdes_tx_data(sdb), .serdes_tx_hdr(shb),
    .serdes_tx_valid(svb), .cfg_am_enable(en_b),
    .stat_am_inserted(stb)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_a = -1;
  bit   chk_space = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic [7:0]  m_bip [2][4];
  logic [63:0] m_bd  [2][4];
  logic [1:0]  m_bh  [2][4];
  int          m_lane[2];
  int          m_cnt [2];
  bit          m_en  [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic int nl(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int np(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  // bit i of the block lands on parity bit i mod 8
  function automatic logic [7:0] bipf(input logic [63:0] d,
                                      input logic [1:0] h);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 64; i++) r[i % 8] = r[i % 8] ^ d[i];
    r[3] = r[3] ^ h[0];
    r[4] = r[4] ^ h[1];
    return r;
  endfunction

  // m holds M0 M1 M2 in reading order
  function automatic logic [63:0] am_exp(input int l,
                                         input logic [7:0] b);
    logic [23:0] m;
    case (l)
      0: m = 24'h907647;
      1: m = 24'hF0C4E6;
      2: m = 24'hC5659B;
      default: m = 24'hA2793D;
    endcase
    return {~b, ~m[7:0], ~m[15:8], ~m[23:16],
            b, m[7:0], m[15:8], m[23:16]};
  endfunction

  task automatic push(input int u, input exp_t e);
    if (u == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic m_am(input int u);
    exp_t e;
    logic [63:0] w;
    e = '0;
    e.s = 1'b1;
    for (int l = 0; l < nl(u); l++) begin
      w = am_exp(l, m_bip[u][l]);
      e.d[l*64 +: 64] = w;
      e.h[l*2 +: 2] = 2'b01;
      m_bip[u][l] = bipf(w, 2'b01);
    end
    push(u, e);
  endtask

  task automatic m_reset(input int u, input bit en);
    for (int l = 0; l < 4; l++) m_bip[u][l] = 8'h00;
    m_lane[u] = 0;
    m_cnt[u] = 0;
    m_en[u] = en;
    if (en) m_am(u);
  endtask

  task automatic m_block(input int u, input logic [63:0] d,
                         input logic [1:0] h);
    exp_t e;
    m_bd[u][m_lane[u]] = d;
    m_bh[u][m_lane[u]] = h;
    m_lane[u]++;
    if (m_lane[u] == nl(u)) begin
      m_lane[u] = 0;
      e = '0;
      for (int l = 0; l < nl(u); l++) begin
        e.d[l*64 +: 64] = m_bd[u][l];
        e.h[l*2 +: 2] = m_bh[u][l];
      end
      push(u, e);
      if (m_en[u]) begin
        for (int l = 0; l < nl(u); l++)
          m_bip[u][l] = m_bip[u][l] ^ bipf(m_bd[u][l], m_bh[u][l]);
        m_cnt[u]++;
        if (m_cnt[u] == np(u)) begin
          m_cnt[u] = 0;
          m_am(u);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (sva === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: strobe with data %h", sda);
      end else begin
        ea = qa.pop_front();
        chk("a_data", sda, ea.d);
        chk("a_hdr", {248'd0, sha}, {248'd0, ea.h});
        chk("a_stat", {255'd0, sta}, {255'd0, ea.s});
      end
      if (chk_space) begin
        if (last_a >= 0) chk("a_spacing", cyc - last_a, 4);
        last_a = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (svb === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: strobe with data %h", sdb);
      end else begin
        eb = qb.pop_front();
        chk("b_data", {192'd0, sdb}, eb.d);
        chk("b_hdr", {254'd0, shb}, {248'd0, eb.h});
        chk("b_stat", {255'd0, stb}, {255'd0, eb.s});
      end
    end
  end

  task automatic send(input int u, input logic [63:0] d,
                      input logic [1:0] h, input bit nostall);
    int t;
    t = 0;
    if (u == 0) begin da = d; ha = h; va = 1'b1; end
    else begin db = d; hb = h; vb = 1'b1; end
    while (((u == 0) ? rdya : rdyb) !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: lane set %0d ready %b", u,
               (u == 0) ? rdya : rdyb);
    end else begin
      if (nostall) chk("ready_held", t, 0);
      m_block(u, d, h);
    end
    @(negedge clk);
    if (u == 1) chk("b_latency", {255'd0, svb}, 256'd1);
    if (u == 0) va = 1'b0;
    else vb = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() + qb.size()) != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; rst_nb = 1'b0;
    va = 1'b0; vb = 1'b0;
    da = '0; db = '0; ha = '0; hb = '0;
    en_a = 1'b0; en_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {255'd0, rdya}, 256'd0);
    chk("rst_valid", {255'd0, sva}, 256'd0);
    chk("rst_data", sda, 256'd0);
    chk("rst_stat", {255'd0, sta}, 256'd0);

    // AM insertion disabled: plain regrouping, ready never drops
    m_reset(0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("init_ready_low", {255'd0, rdya}, 256'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++)
      send(0, 64'h0123_4567_0000_0000 + 64'(k * 3 + 1),
           (k % 2 == 1) ? 2'b01 : 2'b10, 1'b1);
    drain();

    // AM enabled, continuous input
    en_a = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    m_reset(0, 1'b1);
    rst_n = 1'b1;
    last_a = -1;
    chk_space = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("am_ready_low", {255'd0, rdya}, 256'd0);
      @(negedge clk);
    end
    chk("am0_valid", {255'd0, sva}, 256'd1);
    chk("am0_lane0", {192'd0, sda[63:0]},
        {192'd0, 64'hFFB8896F00477690});
    for (int k = 0; k < 16; k++) send(0, 64'h1, 2'b10, 1'b0);
    t = 0;
    while (sta !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("am1_lane0", {192'd0, sda[63:0]},
        {192'd0, 64'hF7B8896F08477690});
    @(negedge clk);
    chk_space = 1'b0;
    drain();

    // same traffic shape with gaps and varied payloads
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(0, {8'(k), 8'hA5, 16'(k * 257), 32'hC0DE_0000 + 32'(k)},
           (k % 3 == 0) ? 2'b01 : 2'b10, 1'b0);
    end
    drain();

    // reset in the middle of a word
    send(0, 64'hDEAD_BEEF_0000_0001, 2'b10, 1'b0);
    send(0, 64'hDEAD_BEEF_0000_0002, 2'b10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_data", sda, 256'd0);
    chk("arst_hdr", {248'd0, sha}, 256'd0);
    chk("arst_ready", {255'd0, rdya}, 256'd0);
    @(negedge clk);
    m_reset(0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      send(0, 64'h5555_0000_0000_0000 + 64'(k), 2'b10, 1'b0);
    drain();

    // single lane, AM every two data blocks
    m_reset(1, 1'b1);
    rst_nb = 1'b1;
    chk("b_ready_low", {255'd0, rdyb}, 256'd0);
    @(negedge clk);
    for (int k = 0; k < 6; k++)
      send(1, 64'h0BAD_F00D_0000_0010 + 64'(k),
           (k == 3) ? 2'b01 : 2'b10, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_eth_phy_mld_tx.md
# taxi_eth_phy_mld_tx

Multi-lane distribution (MLD) transmit stage for multi-lane BASE-R PHYs (2×/4× 10G lanes, e.g. 40GBASE-R). It sits between the 64b/66b encoder and scrambler output and the per-lane SERDES interfaces. It round-robins scrambled 66-bit blocks across `LANES` lanes. It also periodically inserts per-lane alignment markers (AMs) carrying a BIP-8 parity field.

## Interface
- `DATA_W`, default 64: block payload width; only 64 is supported.
- `HDR_W`, default 2: sync header width; only 2 is supported.
- `LANES`, default 4: lane count; legal values are 1, 2 and 4.
- `AM_PERIOD`, default 16383: number of data words (per lane) between AMs; must be ≥ 1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `encoded_tx_data`  in  64  scrambled block payload; byte 0 is in bits 7:0.
- `encoded_tx_hdr`  in  2  sync header; 2'b10 is data, 2'b01 is control.
- `encoded_tx_valid`  in  1  input block valid.
- `encoded_tx_ready`  out  1  the block accepts the input when valid and ready are both high.
- `serdes_tx_data`  out  LANES*64  lane l occupies bits [l*64 +: 64].
- `serdes_tx_hdr`  out  LANES*2  lane l occupies bits [l*2 +: 2].
- `serdes_tx_valid`  out  1  one-cycle strobe; all lanes update together.
- `cfg_am_enable`  in  1  enables AM insertion.
- `stat_am_inserted`  out  1  pulses together with the valid strobe of an AM word.

## Operation
- Data phase:
  - `encoded_tx_ready` = 1.
  - Each accepted block is written to lane slot `lane_idx`, and `lane_idx` then increments.
  - When the block for slot LANES-1 is accepted, the full word is registered to the outputs and `lane_idx` wraps to 0.
  - If valid is low, `lane_idx` holds. There is no idle fill.
- AM phase:
  - `encoded_tx_ready` = 0 for exactly LANES cycles, with `lane_idx` advancing every cycle unconditionally.
  - The AM word is emitted next.
  - For each lane l, the AM word is: hdr 2'b01; bytes 0–7 = M0, M1, M2, BIP3, ~M0, ~M1, ~M2, BIP7, with BIP7 = ~BIP3.
  - M0/M1/M2 per lane are:
    - lane 0: 90 76 47
    - lane 1: F0 C4 E6
    - lane 2: C5 65 9B
    - lane 3: A2 79 3D
- BIP per lane:
  - f(block) bit i = XOR of data bits i, i+8, …, i+56.
  - In addition, hdr bit 0 is XORed into bit 3 and hdr bit 1 into bit 4.
  - `bip[l]` ^= f(block) for every block emitted on lane l.
  - When an AM is emitted, BIP3 = the current `bip[l]`, and `bip[l]` is then loaded with f(AM as sent). The BIP therefore covers the previous AM and excludes the current one.
- AM counter:
  - Counts emitted data words in the range 0..AM_PERIOD-1.
  - On wrap, the next phase is an AM phase.
  - After reset, the first phase is an AM phase.
- `cfg_am_enable` is sampled only when `lane_idx` = 0 at a phase boundary.
  - While it is 0: no AM phases occur, and the counter and `bip` are held at 0.
  - When it rises: the next phase is an AM phase.

## Timing
- Reset values:
  - all outputs 0, except `encoded_tx_ready`, which is 0 because the block starts in the AM phase;
  - `lane_idx` = 0, AM counter = 0, `bip` = 0.
- Reset is asynchronous. A partial word is discarded and never emitted.
- Latency:
  - The last block of a word is accepted at edge N; `serdes_tx_valid` is high during the cycle after edge N, for exactly one cycle.
  - `serdes_tx_data`/`serdes_tx_hdr` hold their value until the next word.
- The AM word is valid the cycle after the last ready-low cycle.
- With continuous input, the output strobe occurs exactly every LANES cycles, AM words included.
- With LANES = 1, `serdes_tx_valid` follows each accepted block by one cycle; an AM phase lasts one cycle.

## Structure
- Package `taxi_eth_mld_pkg`:
  - `SYNC_DATA` and `SYNC_CTRL` constants;
  - the 4×3-byte AM table;
  - function `bip8_calc(data, hdr)`.
- Sub-module `taxi_eth_mld_bip`: per-lane BIP accumulator with `load`, `accumulate` and `value` signals, generated LANES times.
- The top level contains the phase/`lane_idx` FSM, the AM counter and the output registers.

## Test plan
- LANES=4, AM_PERIOD=4, `cfg_am_enable`=1, release reset → ready low for 4 cycles, then an AM word; lane 0 = 64'hFFB8896F00477690, hdr 01; `stat_am_inserted`=1.
- Then 16 blocks with data 64'h1 and hdr 10, valid held high → 4 data words with lane i carrying blocks 4k+i, one strobe every 4 cycles; the next AM on lane 0 has bytes 90 76 47 08 6F 89 B8 F7.
- Same stimulus with valid toggling pseudo-randomly → identical word sequence; only the strobe spacing changes.
- `cfg_am_enable`=0 → ready never drops after the initial AM phase; no `stat_am_inserted`; output = input regrouped by 4.
- `rst_n` low after 2 of 4 blocks → outputs 0 immediately; after release, the first output is an AM and the 2 partial blocks never appear.
- LANES=1, AM_PERIOD=2 → the sequence is AM, D, D, AM, …; each data block is output one cycle after acceptance.
